// File: rtl/beacon_freq_classifier.sv
// Multi-channel blink-rate classifier: counts synchronised rising edges per window,
// bins them into a class code, and locks a channel once CONFIRM consecutive windows agree.
module beacon_freq_classifier #(
    parameter int NUM_CH        = 4,
    parameter int WINDOW_CYCLES = 1000000,
    parameter int CNT_W         = 16,
    parameter int BIN_SHIFT     = 4,
    parameter int CLASS_W       = 3,
    parameter int CONFIRM       = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_continuous,
    input  logic [NUM_CH-1:0]         i_blinky,
    output logic                      o_busy,
    output logic [NUM_CH*CLASS_W-1:0] o_final_answer,
    output logic                      o_final_done,
    output logic [NUM_CH-1:0]         o_locked,
    output logic [NUM_CH-1:0]         o_IRlights
);
    localparam int TIMER_W = $clog2(WINDOW_CYCLES);
    localparam int AGREE_W = $clog2(CONFIRM + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CLASS_W-1:0] CLASS_MAX  = {CLASS_W{1'b1}};
    localparam logic [AGREE_W-1:0] AGREE_MAX  = AGREE_W'(CONFIRM);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DECIDE} state_t;

    function automatic logic [CNT_W-1:0] f_cnt_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CLASS_W-1:0] f_class(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] bin;
        bin = v >> BIN_SHIFT;
        if (bin > CNT_W'(CLASS_MAX))
            return CLASS_MAX;
        return bin[CLASS_W-1:0];
    endfunction

    function automatic logic [AGREE_W-1:0] f_agree_inc(input logic [AGREE_W-1:0] v);
        return (v >= AGREE_MAX) ? AGREE_MAX : v + AGREE_W'(1);
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [NUM_CH-1:0]     r_sync1;
    logic [NUM_CH-1:0]     r_sync2;
    logic [NUM_CH-1:0]     r_sync_prev;
    logic [NUM_CH-1:0]     w_strobe;
    logic [TIMER_W-1:0]    r_timer;
    logic [CNT_W-1:0]      r_cnt      [NUM_CH];
    logic [AGREE_W-1:0]    r_agree    [NUM_CH];
    logic [CLASS_W-1:0]    r_prev_cls [NUM_CH];
    logic [CLASS_W-1:0]    w_cls      [NUM_CH];
    logic [AGREE_W-1:0]    w_agree_nxt[NUM_CH];
    logic [NUM_CH-1:0]     w_lock_nxt;
    logic [NUM_CH-1:0]     r_locked;
    logic [NUM_CH*CLASS_W-1:0] r_answer;
    logic                  r_done;

    assign w_strobe = r_sync2 & ~r_sync_prev;

    // agree == 0 marks "no previous window since start", so the first decision always yields 1
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_cls[ch] = f_class(r_cnt[ch]);
            if (r_agree[ch] == '0 || w_cls[ch] != r_prev_cls[ch])
                w_agree_nxt[ch] = AGREE_W'(1);
            else
                w_agree_nxt[ch] = f_agree_inc(r_agree[ch]);
            w_lock_nxt[ch] = (w_agree_nxt[ch] >= AGREE_MAX);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_MEASURE;
            S_MEASURE: if (r_timer == TIMER_LAST) w_next = S_DECIDE;
            S_DECIDE:  w_next = (!i_continuous && (&w_lock_nxt)) ? S_IDLE : S_MEASURE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync_prev <= '0;
            r_timer     <= '0;
            r_locked    <= '0;
            r_answer    <= '0;
            r_done      <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cnt[ch]      <= '0;
                r_agree[ch]    <= '0;
                r_prev_cls[ch] <= '0;
            end
        end else begin
            r_sync1     <= i_blinky;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_timer  <= '0;
                        r_locked <= '0;
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            r_cnt[ch]      <= '0;
                            r_agree[ch]    <= '0;
                            r_prev_cls[ch] <= '0;
                        end
                    end
                end
                S_MEASURE: begin
                    r_timer <= r_timer + TIMER_W'(1);
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (w_strobe[ch]) r_cnt[ch] <= f_cnt_inc(r_cnt[ch]);
                end
                S_DECIDE: begin
                    r_timer  <= '0;
                    r_locked <= w_lock_nxt;
                    r_done   <= &w_lock_nxt;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        r_cnt[ch]      <= '0;
                        r_agree[ch]    <= w_agree_nxt[ch];
                        r_prev_cls[ch] <= w_cls[ch];
                        if (w_lock_nxt[ch]) r_answer[ch*CLASS_W +: CLASS_W] <= w_cls[ch];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++)
            o_IRlights[ch] = r_locked[ch] && (r_answer[ch*CLASS_W +: CLASS_W] != '0);
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_final_answer = r_answer;
    assign o_final_done   = r_done;
    assign o_locked       = r_locked;
endmodule

// File: tb/tb_beacon_freq_classifier.sv
// Randomised and directed bench for beacon_freq_classifier with a window-level reference model.
module tb_beacon_freq_classifier;
    localparam int NUM_CH = 2;
    localparam int WIN    = 100;
    localparam int SHIFT  = 2;
    localparam int CLS_W  = 3;
    localparam int CONF   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [1:0]  blinky = 2'b00;
    logic        busy, done;
    logic [5:0]  ans;
    logic [1:0]  locked, ir;

    int vectors = 0;
    int miscompares = 0;

    int m_agree[2];
    int m_prev[2];
    int m_ans[2];
    bit m_lock[2];
    bit m_done;
    bit m_busy;

    beacon_freq_classifier #(
        .NUM_CH(NUM_CH), .WINDOW_CYCLES(WIN), .CNT_W(16),
        .BIN_SHIFT(SHIFT), .CLASS_W(CLS_W), .CONFIRM(CONF)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_continuous(cont),
        .i_blinky(blinky), .o_busy(busy), .o_final_answer(ans),
        .o_final_done(done), .o_locked(locked), .o_IRlights(ir)
    );

    always #5 clk = ~clk;

    // Each window: n one-cycle-high pulses every 2 cycles, kept well inside the window.
    function automatic bit pat(input int c, input int n);
        return (c >= 10) && (c < 10 + 2 * n) && (((c - 10) % 2) == 0);
    endfunction

    function automatic int cls_of(input int n);
        int c;
        c = n / (1 << SHIFT);
        return (c > 7) ? 7 : c;
    endfunction

    function automatic logic [5:0] m_ans_vec();
        return {m_ans[1][2:0], m_ans[0][2:0]};
    endfunction

    function automatic logic [1:0] m_lock_vec();
        return {m_lock[1], m_lock[0]};
    endfunction

    function automatic logic [1:0] m_ir_vec();
        return {m_lock[1] && m_ans[1] != 0, m_lock[0] && m_ans[0] != 0};
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_agree[ch] = 0; m_prev[ch] = 0; m_ans[ch] = 0; m_lock[ch] = 0;
        end
        m_done = 0; m_busy = 0;
    endtask

    task automatic model_start();
        for (int ch = 0; ch < 2; ch++) begin
            m_agree[ch] = 0; m_prev[ch] = 0; m_lock[ch] = 0;
        end
        m_busy = 1;
    endtask

    task automatic model_decide(input int n0, input int n1);
        int n[2];
        int c;
        n[0] = n0; n[1] = n1;
        for (int ch = 0; ch < 2; ch++) begin
            c = cls_of(n[ch]);
            if (m_agree[ch] == 0 || c != m_prev[ch]) m_agree[ch] = 1;
            else if (m_agree[ch] < CONF) m_agree[ch] = m_agree[ch] + 1;
            m_prev[ch] = c;
            m_lock[ch] = (m_agree[ch] >= CONF);
            if (m_lock[ch]) m_ans[ch] = c;
        end
        m_done = m_lock[0] && m_lock[1];
        m_busy = cont || !m_done;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        model_start();
    endtask

    // Drives one full window (100 MEASURE cycles + DECIDE); returns sampled just after the decision edge.
    task automatic run_window(input int n0, input int n1, input int start_at, output int early_done);
        early_done = 0;
        for (int c = 0; c <= WIN; c++) begin
            @(negedge clk);
            blinky = {pat(c, n1), pat(c, n0)};
            start  = (c == start_at);
            @(posedge clk); #1;
            if (c < WIN && done) early_done++;
        end
        start = 1'b0;
        model_decide(n0, n1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); blinky = blinky ^ 2'b11;
        end
        @(posedge clk); #1;
        model_reset();
        vectors++;
        if ({busy, done, ans, locked, ir} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", {busy, done, ans, locked, ir}, 11'b0);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); blinky = blinky ^ 2'b01;
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || locked !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_start: got busy=%b done=%b locked=%b want 0 0 00", busy, done, locked);
        end
        @(negedge clk); blinky = 2'b00;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_basic();
        int ed;
        cont = 1'b0;
        do_start();
        run_window(10, 25, -1, ed);
        vectors++;
        if (done !== 1'b0 || ed != 0 || busy !== 1'b1 || locked !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_w1: got done=%b early=%0d busy=%b locked=%b want 0 0 1 00", done, ed, busy, locked);
        end
        run_window(10, 25, -1, ed);
        vectors++;
        if (done !== 1'b1 || ed != 0) begin
            miscompares++;
            $display("FAIL basic_w2_done: got done=%b early=%0d want 1 0", done, ed);
        end
        vectors++;
        if (ans !== 6'b110_010 || ans !== m_ans_vec()) begin
            miscompares++;
            $display("FAIL basic_answer: got %b want %b", ans, 6'b110_010);
        end
        vectors++;
        if (locked !== 2'b11 || ir !== 2'b11 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_lock_ir_busy: got %b %b %b want 11 11 0", locked, ir, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse_width: got %b want 0", done);
        end
    endtask

    task automatic test_clamp_zero();
        int ed;
        cont = 1'b0;
        do_start();
        run_window(40, 0, -1, ed);
        run_window(40, 0, -1, ed);
        vectors++;
        if (ans !== {3'd0, 3'd7} || ans !== m_ans_vec()) begin
            miscompares++;
            $display("FAIL clamp_answer: got %b want %b", ans, {3'd0, 3'd7});
        end
        vectors++;
        if (locked !== 2'b11 || ir !== 2'b01 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_flags: got locked=%b ir=%b done=%b busy=%b want 11 01 1 0", locked, ir, done, busy);
        end
    endtask

    task automatic test_relock();
        int ed;
        cont = 1'b0;
        do_start();
        run_window(10, 12, -1, ed);
        run_window(20, 12, -1, ed);
        vectors++;
        if (locked !== 2'b10 || done !== 1'b0 || busy !== 1'b1 || locked !== m_lock_vec()) begin
            miscompares++;
            $display("FAIL relock_w2: got locked=%b done=%b busy=%b want 10 0 1", locked, done, busy);
        end
        run_window(20, 12, -1, ed);
        vectors++;
        if (locked !== 2'b11 || done !== 1'b1 || busy !== 1'b0 || ans[2:0] !== 3'd5) begin
            miscompares++;
            $display("FAIL relock_w3: got locked=%b done=%b busy=%b cls0=%0d want 11 1 0 5", locked, done, busy, ans[2:0]);
        end
    endtask

    task automatic test_reset_mid();
        int ed;
        cont = 1'b0;
        do_start();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); blinky = {pat(c, 30), pat(c, 30)};
            @(posedge clk);
        end
        @(negedge clk); rst = 1'b1; blinky = 2'b00;
        @(posedge clk); #1;
        model_reset();
        vectors++;
        if ({busy, done, ans, locked, ir} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b want %b", {busy, done, ans, locked, ir}, 11'b0);
        end
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        do_start();
        run_window(8, 4, -1, ed);
        run_window(8, 4, -1, ed);
        vectors++;
        if (ans !== {3'd1, 3'd2} || done !== 1'b1 || ans !== m_ans_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_recount: got ans=%b done=%b want %b 1", ans, done, {3'd1, 3'd2});
        end
    endtask

    task automatic test_continuous();
        int ed;
        cont = 1'b1;
        do_start();
        for (int w = 0; w < 4; w++) begin
            run_window(16, 28, 50, ed);
            vectors++;
            if (done !== (w >= 1) || ed != 0 || busy !== 1'b1 || done !== m_done) begin
                miscompares++;
                $display("FAIL cont_w%0d: got done=%b early=%0d busy=%b want %b 0 1", w, done, ed, busy, (w >= 1));
            end
        end
        vectors++;
        if (ans !== {3'd7, 3'd4} || ir !== 2'b11) begin
            miscompares++;
            $display("FAIL cont_answer: got %b ir=%b want %b 11", ans, ir, {3'd7, 3'd4});
        end
        cont = 1'b0;
        run_window(16, 28, -1, ed);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_stop: got done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_random();
        int ed, n0, n1;
        cont = 1'b0;
        for (int s = 0; s < 5; s++) begin
            do_start();
            n0 = $urandom_range(0, 40);
            n1 = $urandom_range(0, 40);
            for (int w = 0; w < 10 && m_busy; w++) begin
                if (w < 6 && $urandom_range(0, 1) == 1) n0 = $urandom_range(0, 40);
                if (w < 6 && $urandom_range(0, 1) == 1) n1 = $urandom_range(0, 40);
                run_window(n0, n1, -1, ed);
                vectors++;
                if (done !== m_done || locked !== m_lock_vec() || ans !== m_ans_vec() ||
                    ir !== m_ir_vec() || busy !== m_busy || ed != 0) begin
                    miscompares++;
                    $display("FAIL rand_s%0d_w%0d: got done=%b lock=%b ans=%b ir=%b busy=%b early=%0d want %b %b %b %b %b 0",
                             s, w, done, locked, ans, ir, busy, ed,
                             m_done, m_lock_vec(), m_ans_vec(), m_ir_vec(), m_busy);
                end
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_s%0d_idle: got busy=%b want 0", s, busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_clamp_zero();
        test_relock();
        test_reset_mid();
        test_continuous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
